// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle control FSM for the stack CPU datapath.
// Fetches into IR, decodes the 6-bit opcode, then sequences the stack pops,
// the ALU execute and the result push. PC advances only on retire.
// Optional feature macro: STACK_SEQ_BOUNDS_CHECK_EN (stack depth checks in DECODE).
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | stopped, waiting for run
// FETCH    | ir_load when run=1, else back to IDLE
// DECODE   | opcode classified, NOP retires here (pc_inc)
// PUSH_IMM | push zero-extended immediate, retire
// POP1     | discard stack top, retire
// POP_A    | pop top into operand A
// POP_B    | pop next into operand B
// EXEC     | ALU runs A op B, result and zero flag latched
// WB       | push ALU result, retire
// HALT     | terminal until reset, PC parked on the HALT word
// FAULT    | terminal until reset, fault and fault_code held

module stack_sequencer #(
    parameter int DEPTH_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic [DEPTH_W:0]   stack_depth,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               push,
    output logic               pop,
    output logic               push_sel,
    output logic               opa_load,
    output logic               opb_load,
    output logic               res_load,
    output logic [3:0]         alu_op,
    output logic               busy,
    output logic               fault,
    output logic [1:0]         fault_code
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PUSH_IMM,
        S_POP1,
        S_POP_A,
        S_POP_B,
        S_EXEC,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_PUSH = 6'h01;
    localparam logic [5:0] OP_POP  = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [1:0] FC_UNDERFLOW = 2'b01;
    localparam logic [1:0] FC_OVERFLOW  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL   = 2'b11;

    state_t     state;
    state_t     state_n;
    logic [1:0] code_n;

    logic pc_inc_q;
    logic push_q;
    logic pop_q;
    logic push_sel_q;
    logic opa_load_q;
    logic opb_load_q;
    logic res_load_q;
    logic busy_q;
    logic fault_q;
    logic [1:0] fault_code_q;

    logic is_alu;
    logic ovf_push;
    logic unf_pop;
    logic unf_alu;

    assign is_alu = (opcode >= 6'h03) && (opcode <= 6'h08);

`ifdef STACK_SEQ_BOUNDS_CHECK_EN
    localparam logic [DEPTH_W:0] FULL = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0] TWO  = (DEPTH_W+1)'(2);

    assign ovf_push = (stack_depth == FULL);
    assign unf_pop  = (stack_depth == '0);
    assign unf_alu  = (stack_depth < TWO);
`else
    // Depth is not consulted in this build; the stack saturates on its own.
    logic unused_stack_depth;
    assign unused_stack_depth = ^stack_depth;
    assign ovf_push = 1'b0;
    assign unf_pop  = 1'b0;
    assign unf_alu  = 1'b0;
`endif

    // Next-state and fault-code selection.
    always_comb begin
        state_n = state;
        code_n  = fault_code_q;
        case (state)
            S_IDLE:     if (run) state_n = S_FETCH;
            S_FETCH:    state_n = run ? S_DECODE : S_IDLE;
            S_DECODE: begin
                if (opcode == OP_NOP) begin
                    state_n = S_FETCH;
                end else if (opcode == OP_PUSH) begin
                    if (ovf_push) begin
                        state_n = S_FAULT;
                        code_n  = FC_OVERFLOW;
                    end else begin
                        state_n = S_PUSH_IMM;
                    end
                end else if (opcode == OP_POP) begin
                    if (unf_pop) begin
                        state_n = S_FAULT;
                        code_n  = FC_UNDERFLOW;
                    end else begin
                        state_n = S_POP1;
                    end
                end else if (is_alu) begin
                    if (unf_alu) begin
                        state_n = S_FAULT;
                        code_n  = FC_UNDERFLOW;
                    end else begin
                        state_n = S_POP_A;
                    end
                end else if (opcode == OP_HALT) begin
                    state_n = S_HALT;
                end else begin
                    state_n = S_FAULT;
                    code_n  = FC_ILLEGAL;
                end
            end
            S_PUSH_IMM: state_n = S_FETCH;
            S_POP1:     state_n = S_FETCH;
            S_POP_A:    state_n = S_POP_B;
            S_POP_B:    state_n = S_EXEC;
            S_EXEC:     state_n = S_WB;
            S_WB:       state_n = S_FETCH;
            S_HALT:     state_n = S_HALT;
            S_FAULT:    state_n = S_FAULT;
            default:    state_n = S_IDLE;
        endcase
    end

    // State register; strobes are decoded from the state being entered so they
    // are registered and line up with the cycle spent in that state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            pc_inc_q     <= 1'b0;
            push_q       <= 1'b0;
            pop_q        <= 1'b0;
            push_sel_q   <= 1'b0;
            opa_load_q   <= 1'b0;
            opb_load_q   <= 1'b0;
            res_load_q   <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            state        <= state_n;
            pc_inc_q     <= (state_n == S_PUSH_IMM) || (state_n == S_POP1) || (state_n == S_WB);
            push_q       <= (state_n == S_PUSH_IMM) || (state_n == S_WB);
            pop_q        <= (state_n == S_POP1) || (state_n == S_POP_A) || (state_n == S_POP_B);
            push_sel_q   <= (state_n == S_WB);
            opa_load_q   <= (state_n == S_POP_A);
            opb_load_q   <= (state_n == S_POP_B);
            res_load_q   <= (state_n == S_EXEC);
            busy_q       <= (state_n != S_IDLE) && (state_n != S_HALT) && (state_n != S_FAULT);
            fault_q      <= (state_n == S_FAULT);
            fault_code_q <= code_n;
        end
    end

    // ir_load, NOP retire and alu_op depend on inputs seen in the current
    // state, so they are decoded here; everything is held low during reset.
    assign ir_load    = ~reset & (state == S_FETCH) & run;
    assign pc_inc     = ~reset & (pc_inc_q | ((state == S_DECODE) && (opcode == OP_NOP)));
    assign alu_op     = (~reset && (state == S_EXEC)) ? opcode[3:0] : 4'h0;
    assign push       = ~reset & push_q;
    assign pop        = ~reset & pop_q;
    assign push_sel   = ~reset & push_sel_q;
    assign opa_load   = ~reset & opa_load_q;
    assign opb_load   = ~reset & opb_load_q;
    assign res_load   = ~reset & res_load_q;
    assign busy       = ~reset & busy_q;
    assign fault      = ~reset & fault_q;
    assign fault_code = reset ? 2'b00 : fault_code_q;

endmodule
